// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART frame controller
package uart_pkg;
  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;
  typedef enum logic [1:0] {ERR_LEN, ERR_CHK, ERR_TIMEOUT, ERR_OVERRUN} err_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: receiver byte stream, frame handshake, payload read and error signals
interface uart_frame_ctrl_if #(parameter int LENW = 5);
  logic [7:0] rx_data;
  logic rx_done;
  logic frm_valid;
  logic frm_ready;
  logic [7:0] frm_cmd;
  logic [LENW-1:0] frm_len;
  logic [LENW-1:0] rd_addr;
  logic [7:0] rd_data;
  logic err_valid;
  logic [1:0] err_code;
  logic busy;
  modport master(output rx_data, rx_done, frm_ready, rd_addr,
                 input frm_valid, frm_cmd, frm_len, rd_data, err_valid, err_code, busy);
  modport slave(input rx_data, rx_done, frm_ready, rd_addr,
                output frm_valid, frm_cmd, frm_len, rd_data, err_valid, err_code, busy);
endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload RAM, single write port, registered read, no reset
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: hunts SYNC, parses CMD/LEN/payload/XOR checksum, holds validated frames
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 70_000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         LENW        = $clog2(MAX_LEN + 1)
) (
  input logic clk,
  input logic rst,
  uart_frame_ctrl_if.slave bus
);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state;
  err_t err_code;
  logic rx_done_q, frm_valid, err_valid, byte_stb, active, timeout;
  logic [7:0] b, cmd, chk;
  logic [LENW-1:0] len, idx;
  logic [TW-1:0] timer;
  assign b = bus.rx_data;
  // receiver idles high, so rx_done_q resets to 1 to avoid a phantom byte
  assign byte_stb = bus.rx_done & ~rx_done_q;
  assign active = state inside {CMD, LEN, PAYLOAD, CHK};
  assign timeout = active && !byte_stb && timer == TW'(TIMEOUT_CYC - 1);
  assign bus.frm_valid = frm_valid;
  assign bus.frm_cmd = cmd;
  assign bus.frm_len = len;
  assign bus.err_valid = err_valid;
  assign bus.err_code = err_code;
  assign bus.busy = state != HUNT;
  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(IW)) u_buf (
    .clk(clk),
    .we(byte_stb && state == PAYLOAD),
    .waddr(idx[IW-1:0]),
    .wdata(b),
    .raddr(bus.rd_addr[IW-1:0]),
    .rdata(bus.rd_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      rx_done_q <= 1'b1;
      cmd <= '0;
      chk <= '0;
      len <= '0;
      idx <= '0;
      timer <= '0;
      frm_valid <= 1'b0;
      err_valid <= 1'b0;
      err_code <= ERR_LEN;
    end else begin
      rx_done_q <= bus.rx_done;
      err_valid <= 1'b0;
      timer <= (byte_stb || !active) ? '0 : timer + 1'b1;
      if (timeout) begin
        state <= HUNT;
        err_valid <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else begin
        case (state)
          HUNT: if (byte_stb && b == SYNC_BYTE) state <= CMD;
          CMD: if (byte_stb) begin
            cmd <= b;
            chk <= b;
            state <= LEN;
          end
          LEN: if (byte_stb) begin
            if (b > 8'(MAX_LEN)) begin
              state <= HUNT;
              err_valid <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              len <= b[LENW-1:0];
              chk <= chk ^ b;
              idx <= '0;
              state <= b == 8'd0 ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: if (byte_stb) begin
            chk <= chk ^ b;
            idx <= idx + 1'b1;
            if (idx == len - 1'b1) state <= CHK;
          end
          CHK: if (byte_stb) begin
            if (b == chk) begin
              state <= HOLD;
              frm_valid <= 1'b1;
            end else begin
              state <= HUNT;
              err_valid <= 1'b1;
              err_code <= ERR_CHK;
            end
          end
          HOLD: begin
            // a byte arriving with the handshake is the start of the next hunt
            if (bus.frm_ready) begin
              frm_valid <= 1'b0;
              state <= (byte_stb && b == SYNC_BYTE) ? CMD : HUNT;
            end else if (byte_stb) begin
              err_valid <= 1'b1;
              err_code <= ERR_OVERRUN;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: scoreboard bench, frame-level reference model against the frame controller
module tb_uart_frame_ctrl;
  import uart_pkg::*;
  localparam int ML = 16;
  localparam int T = 200;
  localparam int LW = 5;
  typedef struct packed {
    logic is_err;
    logic [1:0] code;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [15:0][7:0] pl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_frame_ctrl_if #(.LENW(LW)) bus ();
  uart_frame_ctrl #(.MAX_LEN(ML), .TIMEOUT_CYC(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  bit auto_accept = 1'b1;
  bit checked = 1'b0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    @(negedge clk);
    bus.rx_data = v;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    e.code = code;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [15:0][7:0] pl);
    exp_t e;
    e = '0;
    e.cmd = cmd;
    e.len = len;
    e.pl = pl;
    q.push_back(e);
  endtask

  // frame outcome derived from the protocol rules, not from parser state
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] lb, input logic [15:0][7:0] pl,
                            input logic [7:0] flip, input int gap);
    logic [7:0] c;
    send_byte(SYNC_DEFAULT, gap);
    send_byte(cmd, gap);
    if (lb > ML) begin
      push_err(ERR_LEN);
      send_byte(lb, gap);
      return;
    end
    send_byte(lb, gap);
    c = cmd ^ lb;
    for (int i = 0; i < int'(lb); i++) begin
      c ^= pl[i];
      send_byte(pl[i], gap);
    end
    if (flip != 0) push_err(ERR_CHK);
    else push_frame(cmd, lb, pl);
    send_byte(c ^ flip, gap);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.frm_valid) && n < 500);
    check("idle_reached", n < 500, 1);
  endtask

  initial begin
    exp_t e;
    bus.frm_ready = 1'b0;
    bus.rd_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (!bus.frm_valid) checked = 1'b0;
      if (bus.err_valid) begin
        if (q.size() == 0) check("unexpected_err", {30'd0, bus.err_code}, 32'hEEEE);
        else begin
          e = q.pop_front();
          check("err_expected", 1, e.is_err);
          check("err_code", bus.err_code, e.code);
        end
      end
      if (bus.frm_valid && !checked) begin
        checked = 1'b1;
        if (q.size() == 0) check("unexpected_frame", bus.frm_cmd, 32'hEEEE);
        else begin
          e = q.pop_front();
          check("frame_expected", 0, e.is_err);
          check("frm_cmd", bus.frm_cmd, e.cmd);
          check("frm_len", bus.frm_len, e.len);
          for (int i = 0; i < int'(e.len); i++) begin
            bus.rd_addr = LW'(i);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", i), bus.rd_data, e.pl[i]);
          end
        end
      end
      if (bus.frm_valid && checked && auto_accept) begin
        bus.frm_ready = 1'b1;
        @(negedge clk);
        bus.frm_ready = 1'b0;
        check("accept_valid_low", bus.frm_valid, 0);
        check("accept_busy_low", bus.busy, 0);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0][7:0] pl;
    logic [7:0] lb, flip, g;
    int k, n;
    bus.rx_done = 1'b1;
    bus.rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_frm_valid", bus.frm_valid, 0);
      check("reset_err_valid", bus.err_valid, 0);
    end
    bus.rx_done = 1'b0;
    pl = '0;
    pl[0] = 8'h11;
    pl[1] = 8'h22;
    pl[2] = 8'h33;
    send_frame(8'h10, 8'd3, pl, 8'h00, 0);
    wait_idle();
    send_frame(8'h10, 8'd3, pl, 8'h07, 1);
    wait_idle();
    send_frame(8'h10, 8'h11, pl, 8'h00, 0);
    wait_idle();
    send_frame(8'h20, 8'd0, pl, 8'h00, 2);
    wait_idle();
    // timeout lands exactly T cycles after the last byte strobe
    send_byte(SYNC_DEFAULT, 0);
    push_err(ERR_TIMEOUT);
    @(negedge clk);
    bus.rx_data = 8'h10;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    for (k = 1; k <= T + 10; k++) begin
      @(negedge clk);
      if (bus.err_valid) break;
    end
    check("timeout_cycles", k, T);
    wait_idle();
    // a byte in the final cycle beats the timeout
    send_byte(SYNC_DEFAULT, 0);
    @(negedge clk);
    bus.rx_data = 8'h10;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    push_frame(8'h10, 8'd0, '0);
    repeat (T - 2) @(negedge clk);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    wait_idle();
    auto_accept = 1'b0;
    pl = '0;
    pl[0] = 8'h77;
    send_frame(8'h30, 8'd1, pl, 8'h00, 0);
    n = 0;
    while (!checked && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_frame_seen", checked, 1);
    push_err(ERR_OVERRUN);
    send_byte(8'h55, 0);
    repeat (2) @(negedge clk);
    check("overrun_keeps_valid", bus.frm_valid, 1);
    check("overrun_keeps_cmd", bus.frm_cmd, 8'h30);
    check("overrun_keeps_len", bus.frm_len, 1);
    @(negedge clk);
    bus.frm_ready = 1'b1;
    bus.rx_data = SYNC_DEFAULT;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.frm_ready = 1'b0;
    bus.rx_done = 1'b0;
    check("handshake_sync_busy", bus.busy, 1);
    check("handshake_valid_low", bus.frm_valid, 0);
    auto_accept = 1'b1;
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    push_frame(8'h40, 8'd0, '0);
    send_byte(8'h40, 0);
    wait_idle();
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        send_byte(g == SYNC_DEFAULT ? 8'h00 : g, $urandom_range(0, 2));
      end
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      lb = $urandom_range(0, 9) == 0 ? 8'($urandom_range(ML + 1, 255)) : 8'($urandom_range(0, ML));
      flip = $urandom_range(0, 4) == 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(8'($urandom), lb, pl, flip, $urandom_range(0, 3));
      wait_idle();
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
